// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-outstanding instruction fetch unit. It requests one word from
// instruction memory, waits for the response, holds that word for the decoder,
// and on consumption computes the next PC from the decoder's control outputs.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request strobe (high only in the request state)
//   imem_addr    fetch address (always equal to pc)
//   imem_rvalid  memory response valid (only honoured while waiting)
//   imem_rdata   memory response word
//   instr        held instruction word (NOP_INSTR when nothing is held)
//   instr_pc     address of instr
//   instr_valid  instr is valid and unconsumed
//   instr_ready  downstream consume strobe
//   enpc         decoder permits the PC to advance
//   jal/jalr/b   decoder control-flow selects for the held instruction
//   flag         ALU branch condition for the held instruction
//   imm_j/b/i    sign-extended immediates of the held instruction
//   rs1_data     register-file rs1 value used by jalr
//   instret      count of consumed instructions (wraps at 2^32)
//   err          sticky misaligned-next-PC flag; the unit halts when it sets
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        enpc,
    input  logic        jal,
    input  logic        jalr,
    input  logic        b,
    input  logic        flag,
    input  logic [31:0] imm_j,
    input  logic [31:0] imm_b,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_data,
    output logic [31:0] instret,
    output logic        err
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] instret_q, instret_d;
    logic        err_q, err_d;

    logic [31:0] jalr_sum;
    logic [31:0] next_pc;
    logic        consume;
    logic        misaligned;

    // Next-PC selection. jalr clears bit 0 of its target before the alignment
    // check, so an odd jalr target is legal but a target with bit 1 set is not.
    always_comb begin
        jalr_sum = rs1_data + imm_i;
        if (jalr) begin
            next_pc = {jalr_sum[31:1], 1'b0};
        end else if (jal) begin
            next_pc = instr_pc_q + imm_j;
        end else if (b && flag) begin
            next_pc = instr_pc_q + imm_b;
        end else begin
            next_pc = instr_pc_q + 32'd4;
        end
    end

    assign consume    = (state_q == ST_HOLD) && instr_ready && enpc;
    assign misaligned = (next_pc[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        instret_d  = instret_q;
        err_d      = err_q;
        case (state_q)
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (consume) begin
                    instret_d = instret_q + 32'd1;
                    instr_d   = NOP_INSTR;
                    if (misaligned) begin
                        // The faulting target is never fetched; pc keeps the
                        // address of the instruction that caused it.
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            instret_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            instret_q  <= instret_d;
            err_q      <= err_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instret     = instret_q;
    assign err         = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed scenarios for reset, sequential fetch, branches, jalr, PC wrap,
// stalls and misaligned halt, followed by randomized traffic. Every cycle the
// DUT outputs are compared with a transaction-level reference model that
// tracks pc, the held word, instret and err from the fetch/consume rules.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Model phases of the fetch loop
    localparam int P_REQ  = 0;
    localparam int P_WAIT = 1;
    localparam int P_HOLD = 2;
    localparam int P_HALT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        enpc, jal, jalr, b, flag;
    logic [31:0] imm_j, imm_b, imm_i, rs1_data;
    logic [31:0] instret;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_ipc, m_instret;
    logic        m_err;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .enpc       (enpc),
        .jal        (jal),
        .jalr       (jalr),
        .b          (b),
        .flag       (flag),
        .imm_j      (imm_j),
        .imm_b      (imm_b),
        .imm_i      (imm_i),
        .rs1_data   (rs1_data),
        .instret    (instret),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next_pc();
        logic [31:0] t;
        if (jalr) begin
            t = rs1_data + imm_i;
            return t & 32'hFFFF_FFFE;
        end
        if (jal)       return m_ipc + imm_j;
        if (b && flag) return m_ipc + imm_b;
        return m_ipc + 32'd4;
    endfunction

    task automatic model_reset();
        m_phase   = P_REQ;
        m_pc      = RESET_PC;
        m_instr   = NOP_INSTR;
        m_ipc     = RESET_PC;
        m_instret = 32'd0;
        m_err     = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [31:0] npc;
        case (m_phase)
            P_REQ:  m_phase = P_WAIT;
            P_WAIT: begin
                if (imem_rvalid) begin
                    m_instr = imem_rdata;
                    m_ipc   = m_pc;
                    m_phase = P_HOLD;
                end
            end
            P_HOLD: begin
                if (instr_ready && enpc) begin
                    npc       = ref_next_pc();
                    m_instret = m_instret + 32'd1;
                    m_instr   = NOP_INSTR;
                    if (npc[1:0] != 2'b00) begin
                        m_err   = 1'b1;
                        m_phase = P_HALT;
                    end else begin
                        m_pc    = npc;
                        m_phase = P_REQ;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_req"},     {31'd0, imem_req},    {31'd0, m_phase == P_REQ});
        check({tag, "_addr"},    imem_addr,            m_pc);
        check({tag, "_valid"},   {31'd0, instr_valid}, {31'd0, m_phase == P_HOLD});
        check({tag, "_instr"},   instr,                m_instr);
        check({tag, "_ipc"},     instr_pc,             m_ipc);
        check({tag, "_instret"}, instret,              m_instret);
        check({tag, "_err"},     {31'd0, err},         {31'd0, m_err});
    endtask

    task automatic idle_ctl();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        enpc = 1'b0; jal = 1'b0; jalr = 1'b0; b = 1'b0; flag = 1'b0;
        imm_j = 32'd0; imm_b = 32'd0; imm_i = 32'd0; rs1_data = 32'd0;
    endtask

    // One clock: model consumes the driven inputs, DUT sees the edge,
    // outputs are sampled 1 ns later.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Reset asserted between edges; rvalid is driven during reset to show it
    // is discarded. Release also happens between edges.
    task automatic do_reset(input int cycles);
        rst_n       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
        model_reset();
        #2;
        check_outputs("rst_async");
        repeat (cycles) @(posedge clk);
        #1;
        check_outputs("rst_hold");
        #2;
        rst_n       = 1'b1;
        imem_rvalid = 1'b0;
        check_outputs("rst_rel");
        check("rst_rel_req", {31'd0, imem_req}, 32'd1);
        check("rst_rel_addr", imem_addr, RESET_PC);
    endtask

    task automatic fetch(input logic [31:0] w);
        idle_ctl();
        tick("f_req");
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        tick("f_wait");
        imem_rvalid = 1'b0;
    endtask

    // Caller sets the control-flow inputs; this adds the consume strobe.
    task automatic consume(input string tag);
        instr_ready = 1'b1;
        enpc        = 1'b1;
        tick(tag);
        idle_ctl();
    endtask

    function automatic logic [31:0] rnd_imm();
        logic [31:0] v;
        v = 32'(int'($urandom_range(0, 64)) - 32) * 32'd4;
        if ($urandom_range(0, 49) == 0) v = v + 32'($urandom_range(1, 3));
        return v;
    endfunction

    initial begin
        logic [31:0] cnt;
        int halted;
        idle_ctl();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // Basic sequential fetch with a zero-wait response
        fetch(32'h0050_0093);
        check("t1_valid", {31'd0, instr_valid}, 32'd1);
        check("t1_ipc", instr_pc, 32'h0);
        check("t1_instr", instr, 32'h0050_0093);
        consume("t1_cons");
        check("t1_next", imem_addr, 32'h4);
        check("t1_instret", instret, 32'd1);

        // Taken / not-taken branches from 0x10
        fetch($urandom); jal = 1'b1; imm_j = 32'hC; consume("j_to10");
        check("j_to10_addr", imem_addr, 32'h10);
        fetch($urandom); b = 1'b1; flag = 1'b1; imm_b = 32'hFFFF_FFF8; consume("br_t");
        check("br_taken", imem_addr, 32'h08);
        fetch($urandom); jal = 1'b1; imm_j = 32'h8; consume("j_back");
        fetch($urandom); b = 1'b1; flag = 1'b0; imm_b = 32'hFFFF_FFF8; consume("br_nt");
        check("br_not_taken", imem_addr, 32'h14);

        // Stall in HOLD with spurious rvalid, then an enpc=0 stall, then consume
        fetch(32'hDEAD_BEEF);
        cnt = instret;
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            tick("stall");
            check("stall_instr", instr, 32'hDEAD_BEEF);
            check("stall_ipc", instr_pc, 32'h14);
        end
        idle_ctl();
        instr_ready = 1'b1;
        tick("stall_noen");
        check("stall_noen_valid", {31'd0, instr_valid}, 32'd1);
        consume("stall_cons");
        check("stall_instret", instret, cnt + 32'd1);
        check("stall_next", imem_addr, 32'h18);

        // PC wrap at the top of the address space
        fetch($urandom); jalr = 1'b1; rs1_data = 32'hFFFF_FFFC; consume("to_top");
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch($urandom); consume("wrap");
        check("wrap_addr", imem_addr, 32'h0);

        // jalr clears bit 0; a target with bit 1 set halts
        fetch($urandom); jalr = 1'b1; rs1_data = 32'h101; consume("jalr_ok");
        check("jalr_ok_addr", imem_addr, 32'h100);
        fetch($urandom); jalr = 1'b1; rs1_data = 32'h102; consume("jalr_bad");
        check("jalr_bad_err", {31'd0, err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            imem_rvalid = 1'b1; imem_rdata = $urandom; instr_ready = 1'b1; enpc = 1'b1;
            tick("halt");
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
        end

        // Reset in the middle of WAIT with rvalid arriving during reset
        do_reset(1);
        idle_ctl();
        tick("w_req");
        do_reset(2);
        idle_ctl();
        tick("after_rst");

        // Randomized traffic
        halted = 0;
        for (int i = 0; i < 4000; i++) begin
            imem_rvalid = ($urandom_range(0, 2) != 0);
            imem_rdata  = $urandom;
            instr_ready = ($urandom_range(0, 3) != 0);
            enpc        = ($urandom_range(0, 7) != 0);
            jalr        = ($urandom_range(0, 9) == 0);
            jal         = ($urandom_range(0, 5) == 0);
            b           = ($urandom_range(0, 3) == 0);
            flag        = $urandom_range(0, 1) == 1;
            imm_j       = rnd_imm();
            imm_b       = rnd_imm();
            imm_i       = rnd_imm();
            rs1_data    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) rs1_data = rs1_data | 32'h1;
            if ($urandom_range(0, 39) == 0) rs1_data = rs1_data | 32'h2;
            if (m_phase == P_HALT) halted++;
            if (halted > 8 || $urandom_range(0, 299) == 0) begin
                halted = 0;
                do_reset($urandom_range(1, 3));
            end else begin
                tick("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the value held on instr when no instruction is held.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port imem_req  output  1  SHALL be the fetch request strobe to instruction memory.
REQ-006 Port imem_addr  output  32  SHALL be the fetch address, equal to pc.
REQ-007 Port imem_rvalid  input  1  SHALL mark imem_rdata as valid.
REQ-008 Port imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-009 Port instr  output  32  SHALL carry the held instruction word to the decoder.
REQ-010 Port instr_pc  output  32  SHALL carry the address of instr.
REQ-011 Port instr_valid  output  1  SHALL mark instr as a valid, unconsumed instruction.
REQ-012 Port instr_ready  input  1  SHALL be the downstream consume strobe.
REQ-013 Ports enpc, jal, jalr, b  input  1 each  SHALL be the decoder control outputs for the held instruction.
REQ-014 Port flag  input  1  SHALL be the ALU branch-condition result for the held instruction.
REQ-015 Ports imm_j, imm_b, imm_i  input  32 each  SHALL be the sign-extended immediates of the held instruction.
REQ-016 Port rs1_data  input  32  SHALL be the register-file rs1 value for jalr.
REQ-017 Port instret  output  32  SHALL count consumed instructions.
REQ-018 Port err  output  1  SHALL be a sticky flag for a misaligned next-PC.

Function
REQ-019 FSM states SHALL be REQ, WAIT, HOLD and HALT.
REQ-020 REQ: imem_req=1 (combinational), next state WAIT unconditionally.
REQ-021 WAIT: imem_req=0; on imem_rvalid, capture imem_rdata into instr, instr_pc<=pc, and go to HOLD; otherwise remain in WAIT.
REQ-022 imem_rvalid in any state other than WAIT SHALL be ignored.
REQ-023 HOLD: instr_valid=1; instr_valid SHALL be 0 in all other states.
REQ-024 Consume SHALL occur when state=HOLD and instr_ready=1 and enpc=1; instr_ready=1 with enpc=0 SHALL stall in HOLD with no state change.
REQ-025 On consume: pc<=next_pc, instret<=instret+1 (mod 2^32), instr<=NOP_INSTR, next state REQ.
REQ-026 next_pc priority: jalr -> (rs1_data+imm_i) with bit0 cleared; else jal -> instr_pc+imm_j; else b&flag -> instr_pc+imm_b; else instr_pc+4.
REQ-027 All next_pc additions SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 32'h0.
REQ-028 If next_pc[1:0]!=0 at consume: err<=1, pc is not updated, instret still increments, next state HALT.
REQ-029 HALT SHALL be absorbing: imem_req=0, instr_valid=0; exit only by reset.
REQ-030 Minimum latency SHALL be 3 cycles from REQ to instr_valid=1 (REQ, WAIT with rvalid, HOLD), i.e. a 3-cycle-per-instruction throughput with zero-wait memory and instr_ready held high.

Reset
REQ-031 While rst_n=0, regardless of clk: state=REQ, pc=RESET_PC, instr=NOP_INSTR, instr_pc=RESET_PC, instr_valid=0, instret=0, err=0.
REQ-032 Reset asserted mid-WAIT or mid-HOLD SHALL discard the pending fetch; an imem_rvalid arriving after reset release SHALL only be captured if it occurs in WAIT.
REQ-033 In the first cycle after rst_n rises, the block SHALL be in REQ with imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-034 Reset release, memory returns 32'h00500093 one cycle after req, instr_ready=1, enpc=1, no jumps -> instr_valid for one cycle with instr_pc=0, next imem_addr=4, instret=1.
REQ-035 Held instruction at pc 0x10 with b=1, flag=1, imm_b=-8 -> next imem_addr=0x08; same with flag=0 -> 0x14.
REQ-036 jalr=1, rs1_data=0x101, imm_i=0x0 -> next imem_addr=0x100; jalr=1, rs1_data=0x102, imm_i=0x0 -> err=1, HALT, imem_req stays 0.
REQ-037 pc=0xFFFF_FFFC, plain instruction consumed -> next imem_addr=0x0000_0000.
REQ-038 HOLD with instr_ready=0 for 5 cycles, then 1 -> instr and instr_pc stable for all 6 cycles, single consume, instret +1; spurious imem_rvalid during HOLD ignored.
REQ-039 rst_n pulsed low during WAIT, rvalid arrives during reset -> all outputs at reset values, fetch restarts at RESET_PC.
